// File: rtl/uart_tx_fifo_reader_pkg.sv
// Shared types and helpers for the UART transmit path at the TX FIFO read end.
package uart_tx_fifo_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

    // Clock cycles occupied by one frame: start + data + optional parity + stop bits.
    function automatic int frame_len(input int clks_per_bit, input int data_width,
                                     input int parity_en, input int stop_bits);
        return clks_per_bit * (1 + data_width + parity_en + stop_bits);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_reader_if.sv
// Read-side FIFO handshake between the UART transmitter and the TX byte FIFO.
interface uart_tx_fifo_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  fifo_empty;
    logic                  fifo_pop;

    // Transmitter side: issues pops, consumes data and the empty flag.
    modport master (input fifo_data_out, input fifo_empty, output fifo_pop);
    // FIFO side: answers pops with registered read data.
    modport slave  (output fifo_data_out, output fifo_empty, input fifo_pop);
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: free-running modulo-CLKS_PER_BIT counter, restartable by clear.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Tick marks the last cycle of every bit period.
    assign bit_tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Next count: restart on clear or at the period boundary, else advance.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || bit_tick) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_tx_fifo_reader.sv
// UART transmit engine: pops bytes from the TX FIFO and serializes them as
// start / data (LSB first) / optional parity / 1-2 stop bit frames on a registered line.
module uart_tx_fifo_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tx_enable,
    uart_tx_fifo_reader_if.master fifo,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);
    import uart_tx_fifo_reader_pkg::*;

    // The index counts data bits in DATA and stop bits in STOP.
    localparam int   IDX_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic PAR_INV = (PARITY_ODD != PARITY_EVEN);

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  timer_clr;
    logic                  bit_tick;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (timer_clr),
        .bit_tick (bit_tick)
    );

    assign fifo.fifo_pop = (state_q == FETCH);
    assign tx_busy       = (state_q != IDLE);
    assign tx_done       = (state_q == STOP) && bit_tick && (idx_q == IDX_W'(STOP_BITS - 1));
    assign tx            = tx_q;

    // Next state, datapath updates, and the line level for the upcoming cycle.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        par_d     = par_q;
        timer_clr = 1'b0;
        tx_d      = 1'b1;
        case (state_q)
            IDLE: begin
                if (tx_enable && !fifo.fifo_empty) state_d = FETCH;
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                shreg_d   = fifo.fifo_data_out;
                par_d     = (^fifo.fifo_data_out) ^ PAR_INV;
                timer_clr = 1'b1;
                state_d   = START;
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                    idx_d   = '0;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Line level follows the state being entered so each bit starts on its first cycle.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset drops any in-flight byte and idles the line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed bench: three transmitters (8N1, 8E1, 8O2 at 4 clocks/bit) each fed by a FIFO model.
module tb_uart_tx_fifo_reader;
    import uart_tx_fifo_reader_pkg::*;

    localparam int CPB = 4;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       force_ne = 1'b1;
    logic       en [3]   = '{1'b1, 1'b1, 1'b1};
    logic [7:0] mem [3][16];
    int         wr [3]      = '{0, 0, 0};
    int         rd [3]      = '{0, 0, 0};
    int         pops [3]    = '{0, 0, 0};
    int         bad_pop [3] = '{0, 0, 0};
    logic [7:0] dout [3];
    logic       pop [3];
    logic       tx_w [3];
    logic       busy [3];
    logic       done [3];
    int         npass = 0;
    int         ntot  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gi
        uart_tx_fifo_reader_if #(.DATA_WIDTH(8)) fif ();
        assign fif.fifo_data_out = dout[g];
        assign fif.fifo_empty    = force_ne ? 1'b0 : (rd[g] == wr[g]);
        assign pop[g]            = fif.fifo_pop;
        uart_tx_fifo_reader #(
            .DATA_WIDTH   (8),
            .CLKS_PER_BIT (CPB),
            .PARITY_EN    (g == 0 ? 0 : 1),
            .PARITY_ODD   (g == 2 ? PARITY_ODD : PARITY_EVEN),
            .STOP_BITS    (g == 2 ? 2 : 1)
        ) dut (
            .clock     (clk),
            .reset     (rst),
            .tx_enable (en[g]),
            .fifo      (fif),
            .tx        (tx_w[g]),
            .tx_busy   (busy[g]),
            .tx_done   (done[g])
        );
    end

    // FIFO model: registered read data one cycle after a pop.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (pop[i]) begin
                if (rd[i] == wr[i]) bad_pop[i] <= bad_pop[i] + 1;
                dout[i] <= mem[i][rd[i] % 16];
                rd[i]   <= rd[i] + 1;
                pops[i] <= pops[i] + 1;
            end
        end
    end

    task automatic push(input int i, input logic [7:0] b);
        mem[i][wr[i] % 16] = b;
        wr[i] = wr[i] + 1;
    endtask

    // Returns at the negedge of the first start-bit cycle.
    task automatic wait_start(input int i);
        bit ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx_w[i] === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        ntot++;
        if (!ok) $display("FAIL start_timeout inst %0d: got no start bit, want one within 60 cycles", i);
        else npass++;
    endtask

    // Samples tx once per cycle for n cycles, starting at the current negedge.
    task automatic record(input int i, input int n, output logic [127:0] tr,
                          output int dcnt, output int dat);
        tr = '1; dcnt = 0; dat = -1;
        for (int k = 0; k < n; k++) begin
            tr[k] = tx_w[i];
            if (done[i] === 1'b1) begin dcnt++; dat = k; end
            if (k != n - 1) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int e_pop = 0, e_tx = 0, e_busy = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (pop[i] !== 1'b0) e_pop++;
                if (tx_w[i] !== 1'b1) e_tx++;
                if (busy[i] !== 1'b0) e_busy++;
            end
        end
        ntot++; if (e_pop != 0) $display("FAIL reset_pop: got %0d pop cycles, want 0", e_pop); else npass++;
        ntot++; if (e_tx != 0) $display("FAIL reset_tx: got %0d low cycles, want 0", e_tx); else npass++;
        ntot++; if (e_busy != 0) $display("FAIL reset_busy: got %0d busy cycles, want 0", e_busy); else npass++;
        force_ne = 1'b0;
        rst = 1'b0;
        e_tx = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (tx_w[i] !== 1'b1) e_tx++;
        end
        ntot++; if (pops[0] + pops[1] + pops[2] != 0)
            $display("FAIL empty_no_pop: got %0d pops, want 0", pops[0] + pops[1] + pops[2]); else npass++;
        ntot++; if (e_tx != 0) $display("FAIL empty_tx_idle: got %0d low cycles, want 0", e_tx); else npass++;
    endtask

    task automatic test_single_frame();
        logic [127:0] tr; int dcnt, dat, p0, len;
        bit b_ok;
        len = frame_len(CPB, 8, 0, 1);
        p0 = pops[0];
        push(0, 8'hA5);
        wait_start(0);
        b_ok = (busy[0] === 1'b1);
        record(0, len, tr, dcnt, dat);
        repeat (10) @(negedge clk);
        ntot++; if (tr[39:0] !== 40'hFF0F00F0F0) $display("FAIL a5_frame: got %h want %h", tr[39:0], 40'hFF0F00F0F0); else npass++;
        ntot++; if (dcnt != 1) $display("FAIL a5_done_count: got %0d want 1", dcnt); else npass++;
        ntot++; if (dat != 39) $display("FAIL a5_done_cycle: got %0d want 39", dat); else npass++;
        ntot++; if (!b_ok) $display("FAIL a5_busy: got %b want 1", busy[0]); else npass++;
        ntot++; if (pops[0] - p0 != 1) $display("FAIL a5_pops: got %0d want 1", pops[0] - p0); else npass++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] tr, want; int dcnt, dat, p0;
        want = '1;
        want[125:0] = {40'hF000000FF0, 3'b111, 40'hF000000F00, 3'b111, 40'hF0000000F0};
        p0 = pops[0];
        push(0, 8'h01); push(0, 8'h02); push(0, 8'h03);
        wait_start(0);
        record(0, 126, tr, dcnt, dat);
        repeat (30) @(negedge clk);
        ntot++; if (tr[125:0] !== want[125:0]) $display("FAIL b2b_trace: got %h want %h", tr[125:0], want[125:0]); else npass++;
        ntot++; if (dcnt != 3) $display("FAIL b2b_done_count: got %0d want 3", dcnt); else npass++;
        ntot++; if (dat != 125) $display("FAIL b2b_last_done: got %0d want 125", dat); else npass++;
        ntot++; if (pops[0] - p0 != 3) $display("FAIL b2b_pops: got %0d want 3", pops[0] - p0); else npass++;
    endtask

    task automatic test_parity();
        logic [127:0] tr; int dcnt, dat;
        push(1, 8'h07); push(1, 8'h03);
        wait_start(1);
        record(1, frame_len(CPB, 8, 1, 1), tr, dcnt, dat);
        ntot++; if (tr[43:0] !== 44'hFF00000FFF0) $display("FAIL even_07: got %h want %h", tr[43:0], 44'hFF00000FFF0); else npass++;
        ntot++; if (dat != 43) $display("FAIL even_07_done: got %0d want 43", dat); else npass++;
        wait_start(1);
        record(1, frame_len(CPB, 8, 1, 1), tr, dcnt, dat);
        ntot++; if (tr[43:0] !== 44'hF0000000FF0) $display("FAIL even_03: got %h want %h", tr[43:0], 44'hF0000000FF0); else npass++;
        push(2, 8'h07); push(2, 8'h03);
        wait_start(2);
        record(2, frame_len(CPB, 8, 1, 2), tr, dcnt, dat);
        ntot++; if (tr[47:0] !== 48'hFF000000FFF0) $display("FAIL odd2_07: got %h want %h", tr[47:0], 48'hFF000000FFF0); else npass++;
        ntot++; if (dat != 47 || dcnt != 1) $display("FAIL odd2_07_done: got cycle %0d count %0d want 47 1", dat, dcnt); else npass++;
        wait_start(2);
        record(2, frame_len(CPB, 8, 1, 2), tr, dcnt, dat);
        ntot++; if (tr[47:0] !== 48'hFFF000000FF0) $display("FAIL odd2_03: got %h want %h", tr[47:0], 48'hFFF000000FF0); else npass++;
    endtask

    task automatic test_enable_drop();
        logic [127:0] tr; int dcnt, dat, p0, e_tx;
        p0 = pops[0];
        push(0, 8'h5A); push(0, 8'hC3);
        wait_start(0);
        tr = '1; dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            tr[k] = tx_w[0];
            if (done[0] === 1'b1) dcnt++;
            if (k == 17) en[0] = 1'b0;
            if (k != 39) @(negedge clk);
        end
        ntot++; if (tr[39:0] !== 40'hF0F0FF0F00) $display("FAIL drop_frame: got %h want %h", tr[39:0], 40'hF0F0FF0F00); else npass++;
        ntot++; if (dcnt != 1) $display("FAIL drop_done: got %0d want 1", dcnt); else npass++;
        e_tx = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1) e_tx++;
        end
        ntot++; if (pops[0] - p0 != 1) $display("FAIL drop_pops: got %0d want 1", pops[0] - p0); else npass++;
        ntot++; if (e_tx != 0) $display("FAIL drop_idle_tx: got %0d low cycles want 0", e_tx); else npass++;
        en[0] = 1'b1;
        wait_start(0);
        record(0, 40, tr, dcnt, dat);
        ntot++; if (tr[39:0] !== 40'hFFF0000FF0) $display("FAIL resume_c3: got %h want %h", tr[39:0], 40'hFFF0000FF0); else npass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [127:0] tr; int dcnt, dat, p0;
        p0 = pops[0];
        push(0, 8'h3C); push(0, 8'h99);
        wait_start(0);
        repeat (26) @(negedge clk);
        rst = 1'b1;
        #1;
        ntot++; if (tx_w[0] !== 1'b1) $display("FAIL rst_tx: got %b want 1", tx_w[0]); else npass++;
        ntot++; if (busy[0] !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy[0]); else npass++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_start(0);
        record(0, 40, tr, dcnt, dat);
        repeat (5) @(negedge clk);
        ntot++; if (tr[39:0] !== 40'hFF00FF00F0) $display("FAIL rst_next_99: got %h want %h", tr[39:0], 40'hFF00FF00F0); else npass++;
        ntot++; if (dat != 39) $display("FAIL rst_next_done: got %0d want 39", dat); else npass++;
        ntot++; if (pops[0] - p0 != 2) $display("FAIL rst_pops: got %0d want 2", pops[0] - p0); else npass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_parity();
        test_enable_drop();
        test_reset_mid_frame();
        ntot++;
        if (bad_pop[0] + bad_pop[1] + bad_pop[2] != 0)
            $display("FAIL pop_when_empty: got %0d want 0", bad_pop[0] + bad_pop[1] + bad_pop[2]);
        else npass++;
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1);
    end
endmodule
